// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator sweep checker: FSM state
// encoding, default operand width, tally width and golden tallies.
package cmp_pkg;

    localparam int WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // One extra bit so a counter can hold the full pair count 2^(2*width).
    function automatic int cw_of(input int width);
        return 2 * width + 1;
    endfunction

    localparam int CW_DEF  = cw_of(WIDTH_DEF);
    localparam int EQ_GOLD = 1 << WIDTH_DEF;
    localparam int GT_GOLD = ((1 << (2 * WIDTH_DEF)) - (1 << WIDTH_DEF)) / 2;
    localparam int LT_GOLD = GT_GOLD;

endpackage

// File: rtl/cmp_pair_odometer.sv
// Operand pair generator: a is the high digit, b the low digit, so pairs run
// (0,0),(0,1)..(0,max),(1,0)..(max,max).
module cmp_pair_odometer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    assign last = &{a, b};

    // NOTE: registers are only ever written with <= so every reader sees the
    // value from before the clock edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            a <= '0;
            b <= '0;
        end else if (advance) begin
            {a, b} <= {a, b} + (2 * WIDTH)'(1);
        end
    end

endmodule

// File: rtl/cmp_sweep_checker.sv
// Exhaustive self-test of a WIDTH-bit magnitude comparator: drives every pair,
// samples equal/gt/lt after SETTLE cycles and tallies results and mismatches.
module cmp_sweep_checker
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int SETTLE = 1,
    localparam int CW     = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             equal,
    input  logic             gt,
    input  logic             lt,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    eq_cnt,
    output logic [CW-1:0]    gt_cnt,
    output logic [CW-1:0]    lt_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t          state;
    logic [3:0]      settle_cnt;
    logic            accept;
    logic            last_pair;
    logic            advance_pair;
    logic [2:0]      exp_flags;
    logic            mismatch;
    logic [CW-1:0]   err_next;

    assign accept       = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign advance_pair = (state == S_SAMPLE) && !last_pair;

    cmp_pair_odometer #(
        .WIDTH (WIDTH)
    ) u_odometer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (advance_pair),
        .a       (a),
        .b       (b),
        .last    (last_pair)
    );

    // Multi-hot and zero-hot flag patterns both land here as mismatches.
    assign exp_flags = {a == b, a > b, a < b};
    assign mismatch  = {equal, gt, lt} != exp_flags;
    assign err_next  = err_cnt + CW'(mismatch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            eq_cnt     <= '0;
            gt_cnt     <= '0;
            lt_cnt     <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        eq_cnt     <= '0;
                        gt_cnt     <= '0;
                        lt_cnt     <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end

                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    eq_cnt  <= eq_cnt + CW'(equal);
                    gt_cnt  <= gt_cnt + CW'(gt);
                    lt_cnt  <= lt_cnt + CW'(lt);
                    err_cnt <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a;
                        fail_b     <= b;
                    end
                    if (last_pair) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Self-checking bench: two checkers (SETTLE=1 and SETTLE=3) each driven by a
// behavioural comparator with selectable faults; results go through a scoreboard.
module tb_cmp_sweep_checker;
    import cmp_pkg::*;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [6:0] eq;
        logic [6:0] gt;
        logic [6:0] lt;
        logic [6:0] err;
        logic       fv;
        logic [2:0] fa;
        logic [2:0] fb;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    int   mode1 = 0;
    int   mode3 = 0;

    logic [2:0] a1, b1, fa1, fb1, a3, b3, fa3, fb3;
    logic       eq1, gt1, lt1, busy1, done1, pass1, fv1;
    logic       eq3, gt3, lt3, busy3, done3, pass3, fv3;
    logic [6:0] eqc1, gtc1, ltc1, errc1, eqc3, gtc3, ltc3, errc3;

    obs_t obs1, obs3;
    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // mode 0: correct; 1: gt dropped at (5,2); 2: equal and gt both set when a==7
    function automatic logic [2:0] model_flags(input int mode, input logic [2:0] x,
                                               input logic [2:0] y);
        logic [2:0] f;
        f = {x == y, x > y, x < y};
        if (mode == 1 && x == 3'd5 && y == 3'd2) f[1] = 1'b0;
        if (mode == 2 && x == 3'd7) f[2:1] = 2'b11;
        return f;
    endfunction

    assign {eq1, gt1, lt1} = model_flags(mode1, a1, b1);
    assign {eq3, gt3, lt3} = model_flags(mode3, a3, b3);

    assign obs1 = '{a: a1, b: b1, busy: busy1, done: done1, pass: pass1, eq: eqc1,
                    gt: gtc1, lt: ltc1, err: errc1, fv: fv1, fa: fa1, fb: fb1};
    assign obs3 = '{a: a3, b: b3, busy: busy3, done: done3, pass: pass3, eq: eqc3,
                    gt: gtc3, lt: ltc3, err: errc3, fv: fv3, fa: fa3, fb: fb3};

    cmp_sweep_checker #(.WIDTH(3), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .equal(eq1), .gt(gt1), .lt(lt1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .eq_cnt(eqc1), .gt_cnt(gtc1), .lt_cnt(ltc1), .err_cnt(errc1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    cmp_sweep_checker #(.WIDTH(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .equal(eq3), .gt(gt3), .lt(lt3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .eq_cnt(eqc3), .gt_cnt(gtc3), .lt_cnt(ltc3), .err_cnt(errc3),
        .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    // Expected end-of-sweep picture for a given comparator fault mode.
    function automatic obs_t expected(input int mode);
        obs_t e;
        logic [2:0] f, want;
        e = '0;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                f    = model_flags(mode, 3'(x), 3'(y));
                want = {x == y, x > y, x < y};
                e.eq = e.eq + 7'(f[2]);
                e.gt = e.gt + 7'(f[1]);
                e.lt = e.lt + 7'(f[0]);
                if (f != want) begin
                    e.err = e.err + 7'd1;
                    if (!e.fv) begin
                        e.fv = 1'b1;
                        e.fa = 3'(x);
                        e.fb = 3'(y);
                    end
                end
            end
        end
        e.a    = 3'd7;
        e.b    = 3'd7;
        e.done = 1'b1;
        e.pass = (e.err == 7'd0);
        return e;
    endfunction

    // Runs one sweep; per-cycle it checks busy, the pair schedule and busy/done exclusion.
    task automatic run_sweep(input int sel, input int settle, input bit hold_start,
                             output obs_t first, output obs_t o, output int lat,
                             output int overlap, output int hold_err);
        obs_t cur;
        int   k;
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        if (!hold_start) begin
            start1 = 1'b0;
            start3 = 1'b0;
        end
        lat = 0;
        overlap = 0;
        hold_err = 0;
        first = (sel == 1) ? obs1 : obs3;
        for (;;) begin
            cur = (sel == 1) ? obs1 : obs3;
            if (cur.busy && cur.done) overlap++;
            if (lat < 64 * (settle + 1)) begin
                k = lat / (settle + 1);
                if (cur.a !== 3'(k >> 3) || cur.b !== 3'(k & 7) || cur.busy !== 1'b1)
                    hold_err++;
            end
            if (cur.done === 1'b1 || lat >= 4000) break;
            @(negedge clk);
            lat++;
        end
        start1 = 1'b0;
        start3 = 1'b0;
        o = cur;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs1 !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset_dut1 got=%p want=all-zero", obs1);
        end
        total++;
        if (obs3 !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset_dut3 got=%p want=all-zero", obs3);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        obs_t first, o, e, first_want;
        int lat, ov, he;
        mode1 = 0;
        exp_q.push_back(expected(0));
        run_sweep(1, 1, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        first_want = '0;
        first_want.busy = 1'b1;
        total++;
        if (first !== first_want) begin
            bad++;
            $display("FAIL correct_first got=%p want=%p", first, first_want);
        end
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL correct_result got=%p want=%p", o, e);
        end
        total++;
        if (o.eq !== 7'(EQ_GOLD) || o.gt !== 7'(GT_GOLD) || o.lt !== 7'(LT_GOLD) ||
            o.err !== 7'd0 || o.pass !== 1'b1) begin
            bad++;
            $display("FAIL correct_golden got eq=%0d gt=%0d lt=%0d err=%0d pass=%0b want 8/28/28/0/1",
                     o.eq, o.gt, o.lt, o.err, o.pass);
        end
        total++;
        if (lat !== 128) begin
            bad++;
            $display("FAIL correct_latency got=%0d want=128", lat);
        end
        total++;
        if (ov !== 0 || he !== 0) begin
            bad++;
            $display("FAIL correct_schedule got overlap=%0d sched_err=%0d want 0/0", ov, he);
        end
        repeat (5) @(negedge clk);
        total++;
        if (obs1 !== e) begin
            bad++;
            $display("FAIL correct_done_hold got=%p want=%p", obs1, e);
        end
    endtask

    task automatic test_single_fault();
        obs_t first, o, e;
        int lat, ov, he;
        mode1 = 1;
        exp_q.push_back(expected(1));
        run_sweep(1, 1, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL single_fault_result got=%p want=%p", o, e);
        end
        total++;
        if (o.err !== 7'd1 || o.fa !== 3'd5 || o.fb !== 3'd2 || o.gt !== 7'd27 ||
            o.pass !== 1'b0 || o.fv !== 1'b1) begin
            bad++;
            $display("FAIL single_fault_fields got err=%0d fa=%0d fb=%0d gt=%0d pass=%0b want 1/5/2/27/0",
                     o.err, o.fa, o.fb, o.gt, o.pass);
        end
        mode1 = 0;
    endtask

    task automatic test_multi_hot();
        obs_t first, o, e;
        int lat, ov, he;
        mode1 = 2;
        exp_q.push_back(expected(2));
        run_sweep(1, 1, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL multi_hot_result got=%p want=%p", o, e);
        end
        total++;
        if (o.err !== 7'd8 || o.fa !== 3'd7 || o.fb !== 3'd0 || o.eq !== 7'd15) begin
            bad++;
            $display("FAIL multi_hot_fields got err=%0d fa=%0d fb=%0d eq=%0d want 8/7/0/15",
                     o.err, o.fa, o.fb, o.eq);
        end
        mode1 = 0;
    endtask

    task automatic test_settle3();
        obs_t first, o, e;
        int lat, ov, he;
        mode3 = 0;
        exp_q.push_back(expected(0));
        run_sweep(3, 3, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL settle3_result got=%p want=%p", o, e);
        end
        total++;
        if (lat !== 256) begin
            bad++;
            $display("FAIL settle3_latency got=%0d want=256", lat);
        end
        total++;
        if (ov !== 0 || he !== 0) begin
            bad++;
            $display("FAIL settle3_hold got overlap=%0d sched_err=%0d want 0/0", ov, he);
        end
    endtask

    task automatic test_reset_mid_sweep();
        obs_t first, o, e;
        int lat, ov, he;
        mode1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (39) @(negedge clk);
        total++;
        if (obs1.busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_busy_before got=%0b want=1", obs1.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (obs1 !== obs_t'(0)) begin
            bad++;
            $display("FAIL midreset_zero got=%p want=all-zero", obs1);
        end
        exp_q.push_back(expected(0));
        run_sweep(1, 1, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        total++;
        if (o !== e || lat !== 128) begin
            bad++;
            $display("FAIL midreset_rerun got=%p lat=%0d want=%p lat=128", o, lat, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t first, o, e, first_want;
        int lat, ov, he;
        mode1 = 0;
        exp_q.push_back(expected(0));
        run_sweep(1, 1, 1'b1, first, o, lat, ov, he);
        e = exp_q.pop_front();
        total++;
        if (o !== e || lat !== 128 || ov !== 0 || he !== 0) begin
            bad++;
            $display("FAIL held_start got=%p lat=%0d ov=%0d sched_err=%0d want=%p lat=128 ov=0 sched_err=0",
                     o, lat, ov, he, e);
        end
        exp_q.push_back(expected(0));
        run_sweep(1, 1, 1'b0, first, o, lat, ov, he);
        e = exp_q.pop_front();
        first_want = '0;
        first_want.busy = 1'b1;
        total++;
        if (first !== first_want) begin
            bad++;
            $display("FAIL restart_clear got=%p want=%p", first, first_want);
        end
        total++;
        if (o !== e || lat !== 128) begin
            bad++;
            $display("FAIL restart_result got=%p lat=%0d want=%p lat=128", o, lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_single_fault();
        test_multi_hot();
        test_settle3();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Sequential self-test stage directly upstream of the 3-bit magnitude comparator (inputs a, b; outputs equal, gt, lt).
- Drives every (a, b) pair into the comparator, samples its three flags after a settle time, and checks them against internally computed expected values.
- Tallies eq/gt/lt results and mismatches, and records the first failing pair.
- Used for board-level bring-up and as a synthesizable regression harness.

Parameters:
- WIDTH, 3, operand width; must match the comparator.
- SETTLE, 1, cycles a pair is held before sampling; legal range 1..15.
- CW, 2*WIDTH+1, width of every tally counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- equal  in  1  comparator flag
- gt  in  1  comparator flag
- lt  in  1  comparator flag
- a  out  WIDTH  operand A to comparator
- b  out  WIDTH  operand B to comparator
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until next accepted start or reset
- pass  out  1  valid when done=1; 1 iff err_cnt==0
- eq_cnt  out  CW  pairs sampled with equal=1
- gt_cnt  out  CW  pairs sampled with gt=1
- lt_cnt  out  CW  pairs sampled with lt=1
- err_cnt  out  CW  pairs whose flags mismatched expected
- fail_valid  out  1  a mismatch has been recorded this sweep
- fail_a  out  WIDTH  A of first mismatching pair
- fail_b  out  WIDTH  B of first mismatching pair

Behaviour:
- Reset (rst_n=0 at a clk edge, any state, including mid-sweep):
  - State goes to IDLE.
  - All outputs are 0: a, b, busy, done, pass, all counters, fail_valid, fail_a, fail_b.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, or DONE, with start=1:
  - a and b load 0.
  - All counters, fail_* and done clear.
  - settle_cnt loads SETTLE-1.
  - busy is set and the FSM goes to SETTLE.
- start is ignored in SETTLE and SAMPLE.
- SETTLE:
  - a and b are held.
  - If settle_cnt==0 go to SAMPLE; otherwise decrement it.
  - The FSM therefore spends exactly SETTLE cycles here.
- SAMPLE (exactly one cycle): flags are registered at the end of this cycle.
  - Expected values: exp_eq=(a==b), exp_gt=(a>b), exp_lt=(a<b), unsigned compare.
  - eq_cnt, gt_cnt and lt_cnt each increment by 1 when the corresponding input flag is 1. These are raw tallies and are not one-hot filtered.
  - Mismatch means {equal,gt,lt} != {exp_eq,exp_gt,exp_lt}. This also catches zero-hot and multi-hot flags.
  - On mismatch err_cnt increments. If fail_valid=0, fail_a/fail_b capture a/b and fail_valid sets.
  - If a and b are both all-ones: go to DONE, busy clears, done sets, pass=(next err_cnt==0).
  - Otherwise advance the odometer and go to SETTLE with settle_cnt=SETTLE-1. The odometer increments b; when b wraps from all-ones to 0, a increments. Pair order is (0,0),(0,1)…(0,7),(1,0)…(7,7).
- DONE: a and b hold (7,7); all results hold.
- Latency:
  - busy rises on the edge that accepts start.
  - done rises exactly 2^(2*WIDTH)*(SETTLE+1) cycles later: 128 cycles for the defaults.
  - busy and done are never high together.
- Counters: CW bits hold 2^(2*WIDTH) without overflow. No saturation logic is required.
- Golden tallies for a correct comparator at WIDTH=3: eq=8, gt=28, lt=28, err=0.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - default WIDTH;
  - CW derivation;
  - golden-count constants (EQ_GOLD=2^WIDTH, GT_GOLD=LT_GOLD=(2^(2W)-2^W)/2).
- One sub-module, cmp_pair_odometer: holds the a/b registers and provides clear, advance and a last-pair flag.
- The FSM, settle counter, checker and tallies stay in cmp_sweep_checker.

Test Plan:
1. Correct comparator, SETTLE=1, pulse start -> done at cycle 128 after busy rise; eq=8, gt=28, lt=28, err=0, pass=1, fail_valid=0.
2. Comparator model forcing gt=0 when a=5,b=2 -> err=1, fail_a=5, fail_b=2, gt_cnt=27, pass=0.
3. Model asserting equal and gt together for every pair with a=7 -> err=8, fail_a=7, fail_b=0, eq_cnt=15.
4. SETTLE=3, correct model -> done 256 cycles after busy rise; a/b each held 4 cycles per pair.
5. rst_n low for one cycle at cycle 40 mid-sweep -> next cycle IDLE, all outputs 0; a fresh start yields the scenario-1 results.
6. start held high throughout the sweep, then start pulsed in DONE -> no restart while busy; the DONE pulse clears counters and reruns with identical results.
